// File: rtl/ctrl_seq_pkg.sv
// Shared types and field positions for control_sequencer.
// Microinstruction layout: [17:16] opcode, [15:0] control word or branch/call operands.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_EXEC    = 2'b00,
    OP_BRANCH  = 2'b01,
    OP_HALT    = 2'b10,
    OP_CALLRET = 2'b11
  } opcode_e;

  localparam int CW_W         = 16;
  localparam int CW_SRC_A_LSB = 12;
  localparam int CW_SRC_B_LSB = 8;
  localparam int CW_WE_BIT    = 7;
  localparam int CW_ALU_LSB   = 3;
  localparam int CW_SHF_LSB   = 0;

  localparam int IR_OP_MSB    = 17;
  localparam int IR_OP_LSB    = 16;
  localparam int IR_RET_BIT   = 15;
  localparam int IR_POL_BIT   = 12;
  localparam int IR_MASK_MSB  = 11;
  localparam int IR_MASK_LSB  = 8;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  function automatic opcode_e ir_opcode(input logic [17:0] word);
    return opcode_e'(word[IR_OP_MSB:IR_OP_LSB]);
  endfunction

  // Builds a datapath control word from its individual fields.
  function automatic logic [CW_W-1:0] pack_cw(input logic [3:0] src_a, input logic [3:0] src_b,
                                              input logic we, input logic [3:0] alu,
                                              input logic [2:0] shf);
    logic [CW_W-1:0] cw;
    cw = '0;
    cw[CW_SRC_A_LSB +: 4] = src_a;
    cw[CW_SRC_B_LSB +: 4] = src_b;
    cw[CW_WE_BIT]         = we;
    cw[CW_ALU_LSB +: 4]   = alu;
    cw[CW_SHF_LSB +: 3]   = shf;
    return cw;
  endfunction

endpackage

// File: rtl/control_sequencer_branch_cond.sv
// Branch condition: taken when any masked flag is set, inverted by the polarity bit.
// Mask 0 with polarity 1 is an unconditional jump; mask 0 with polarity 0 never branches.
module branch_cond
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] mask,
  input  logic       pol,
  output logic       taken
);

  logic [3:0] hit;

  assign hit[FLAG_V] = flags[FLAG_V] & mask[FLAG_V];
  assign hit[FLAG_N] = flags[FLAG_N] & mask[FLAG_N];
  assign hit[FLAG_Z] = flags[FLAG_Z] & mask[FLAG_Z];
  assign hit[FLAG_C] = flags[FLAG_C] & mask[FLAG_C];

  assign taken = (|hit) ^ pol;

endmodule

// File: rtl/control_sequencer.sv
// Microprogram sequencer for the register-file/ALU/shifter datapath.
// Define CTRL_SEQ_CALL_EN to enable CALL/RET with a one-entry return register (opcode 11 is a NOP otherwise).
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int AW = 6,
  parameter int IW = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [3:0]    stateBits,
  output logic [15:0]   ctrl_word,
  output logic          busy,
  output logic          halted,
  output logic [3:0]    flags
);

  state_e        state;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
`ifdef CTRL_SEQ_CALL_EN
  logic [AW-1:0] ret;
`endif

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] dec_pc;
  logic [AW-1:0] dec_target;
  opcode_e       dec_op;
  logic          br_taken;

  // pc wraps modulo 2**AW through natural truncation.
  assign pc_inc     = pc + AW'(1);
  assign dec_op     = ir_opcode(prog_data);
  assign dec_target = prog_data[AW-1:0];

  // flags is the latched register, so a branch right after an EXEC already sees its result.
  branch_cond u_branch_cond (
    .flags (flags),
    .mask  (prog_data[IR_MASK_MSB:IR_MASK_LSB]),
    .pol   (prog_data[IR_POL_BIT]),
    .taken (br_taken)
  );

  // NOTE: every path assigns dec_pc first, so this block cannot infer a latch.
  always_comb begin
    dec_pc = pc_inc;
    case (dec_op)
      OP_BRANCH: if (br_taken) dec_pc = dec_target;
`ifdef CTRL_SEQ_CALL_EN
      OP_CALLRET: dec_pc = prog_data[IR_RET_BIT] ? ret : dec_target;
`endif
      default: ;
    endcase
  end

  // Only registered state and ir feed ctrl_word; nothing outside EXEC can cause a write.
  assign ctrl_word = (state == ST_EXEC && ir_opcode(ir) == OP_EXEC) ? ir[CW_W-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      prog_addr <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
`ifdef CTRL_SEQ_CALL_EN
      ret       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state     <= ST_FETCH;
            pc        <= '0;
            prog_addr <= '0;
            busy      <= 1'b1;
            halted    <= 1'b0;
          end
        end

        // prog_addr already holds pc; the memory returns the word during DECODE.
        ST_FETCH: state <= ST_DECODE;

        ST_DECODE: begin
          ir <= prog_data;
          case (dec_op)
            OP_EXEC: state <= ST_EXEC;
            OP_HALT: begin
              state  <= ST_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: begin
              pc        <= dec_pc;
              prog_addr <= dec_pc;
              state     <= ST_FETCH;
`ifdef CTRL_SEQ_CALL_EN
              if (dec_op == OP_CALLRET && !prog_data[IR_RET_BIT]) ret <= pc_inc;
`endif
            end
          endcase
        end

        ST_EXEC: begin
          flags     <= stateBits;
          pc        <= pc_inc;
          prog_addr <= pc_inc;
          state     <= ST_FETCH;
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a synchronous program memory model, an address
// scoreboard fed with expected prog_addr changes, and per-cycle checks of control outputs.
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [17:0]   prog_data = '0;
  logic [3:0]    stateBits = '0;
  logic [15:0]   ctrl_word;
  logic          busy;
  logic          halted;
  logic [3:0]    flags;

  logic [17:0]   mem [64];
  logic [31:0]   exp_q [$];
  logic          mon_en = 1'b0;
  logic [AW-1:0] last_addr = '0;
  int            vectors = 0;
  int            miscompares = 0;

  control_sequencer #(.AW(AW), .IW(18)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .stateBits (stateBits),
    .ctrl_word (ctrl_word),
    .busy      (busy),
    .halted    (halted),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= mem[prog_addr];

  function automatic logic [17:0] exec_w(input logic [15:0] cw);
    return {2'b00, cw};
  endfunction
  function automatic logic [17:0] br_w(input logic [3:0] mask, input logic pol, input logic [5:0] tgt);
    return {2'b01, 3'b000, pol, mask, 2'b00, tgt};
  endfunction
  function automatic logic [17:0] halt_w();
    return {2'b10, 16'h0000};
  endfunction
  function automatic logic [17:0] call_w(input logic [5:0] tgt);
    return {2'b11, 1'b0, 7'b0, 2'b00, tgt};
  endfunction
  function automatic logic [17:0] ret_w();
    return {2'b11, 1'b1, 15'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every change of prog_addr must match the next expected address.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en && prog_addr !== last_addr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      last_addr = prog_addr;
      check("addr_seq", {26'b0, prog_addr}, e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = halt_w();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    step();
    reset  = 1'b0;
    exp_q.delete();
    last_addr = prog_addr;
    mon_en = 1'b1;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 300; i++) begin
      if (halted === 1'b1) break;
      step();
    end
    check("halt_seen", {31'b0, halted}, 32'd1);
  endtask

  task automatic drain(input string tag);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    clear_mem();

    // Reset state and basic EXEC/HALT timing
    mem[0] = exec_w(16'h1288);
    mem[1] = halt_w();
    do_reset();
    check("rst_ctrl_word", {16'b0, ctrl_word}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_flags", {28'b0, flags}, 32'd0);
    check("rst_prog_addr", {26'b0, prog_addr}, 32'd0);
    stateBits = 4'b1010;
    exp_q.push_back(32'd1);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      start = 1'b0;
      check("t1_ctrl_word", {16'b0, ctrl_word}, (i == 2) ? 32'h1288 : 32'h0);
      check("t1_busy", {31'b0, busy}, (i <= 4) ? 32'd1 : 32'd0);
      check("t1_halted", {31'b0, halted}, (i == 5) ? 32'd1 : 32'd0);
    end
    check("t1_flags", {28'b0, flags}, 32'ha);
    drain("t1_drain");

    // Branch taken on Z from the immediately preceding EXEC
    clear_mem();
    mem[0] = exec_w(pack_cw(4'd3, 4'd4, 1'b1, 4'd2, 3'd1));
    mem[1] = br_w(4'b0010, 1'b0, 6'd5);
    do_reset();
    stateBits = 4'b0010;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd5);
    pulse_start();
    wait_halt();
    check("t2_flags", {28'b0, flags}, 32'h2);
    drain("t2_drain");

    // HALTED keeps flags; restart from HALTED with Z clear takes the not-taken path
    stateBits = 4'b0000;
    step();
    step();
    check("t3_flags_kept", {28'b0, flags}, 32'h2);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    pulse_start();
    wait_halt();
    check("t3_flags", {28'b0, flags}, 32'h0);
    drain("t3_drain");

    // Unconditional jump at the last address back to 0
    clear_mem();
    mem[0]  = br_w(4'b0010, 1'b1, 6'd62);
    mem[62] = exec_w(16'h0001);
    mem[63] = br_w(4'b0000, 1'b1, 6'd0);
    do_reset();
    stateBits = 4'b0010;
    exp_q.push_back(32'd62);
    exp_q.push_back(32'd63);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    pulse_start();
    wait_halt();
    drain("t4_jump_drain");

    // Linear program running off the last address wraps to 0
    clear_mem();
    mem[0]  = br_w(4'b0010, 1'b1, 6'd62);
    mem[62] = exec_w(16'h0001);
    mem[63] = exec_w(16'h0002);
    do_reset();
    exp_q.push_back(32'd62);
    exp_q.push_back(32'd63);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    pulse_start();
    wait_halt();
    drain("t4_wrap_drain");

    // Reset asserted during EXEC aborts it without writing flags
    clear_mem();
    mem[0] = exec_w(16'habcd);
    do_reset();
    mon_en = 1'b0;
    stateBits = 4'b1111;
    pulse_start();
    step();
    step();
    check("t5_exec_cw", {16'b0, ctrl_word}, 32'habcd);
    reset = 1'b1;
    step();
    check("t5_ctrl_word", {16'b0, ctrl_word}, 32'h0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_flags", {28'b0, flags}, 32'h0);
    check("t5_prog_addr", {26'b0, prog_addr}, 32'd0);
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    check("t5_reset_wins", {31'b0, busy}, 32'd0);

    // start pulses while busy are ignored
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = exec_w(16'h0010 + 16'(i));
    do_reset();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd4);
    pulse_start();
    step();
    pulse_start();
    step();
    step();
    pulse_start();
    wait_halt();
    check("t6_final_addr", {26'b0, prog_addr}, 32'd4);
    drain("t6_drain");

    // CALL at 3 to 10, RET at 10 back to 4 (NOP advancing to 4 when disabled)
    clear_mem();
    for (int i = 0; i < 3; i++) mem[i] = exec_w(16'h0100);
    mem[3]  = call_w(6'd10);
    mem[10] = ret_w();
    do_reset();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
`ifdef CTRL_SEQ_CALL_EN
    exp_q.push_back(32'd10);
`endif
    exp_q.push_back(32'd4);
    pulse_start();
    wait_halt();
    check("t7_final_addr", {26'b0, prog_addr}, 32'd4);
    drain("t7_drain");

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
